// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a persistent NZCV flag register, carry-chained
// ADC/SBC, logical shifts and an iterative radix-2 shift-add multiplier.
// Single-cycle ops register their result on the accept edge; MUL iterates W cycles.
module alu_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic         set_flags,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [3:0]   flag_out,
    output logic         busy
);
    localparam int SW = $clog2(W);
    localparam logic [SW:0] LAST_ITER = (SW+1)'(W - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3,
        OP_ORR = 4'd4,  OP_EOR = 4'd5,  OP_MOV = 4'd6,  OP_ADC = 4'd7,
        OP_SBC = 4'd8,  OP_MUL = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11
    } op_e;

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [W-1:0] acc;
    logic [SW:0]  cnt;
    logic         mul_sf;

    logic         accept;
    logic [W-1:0] b_op;
    logic         cin;
    logic [W:0]   sum;
    logic [W:0]   shl;
    logic [W:0]   shr;
    logic [SW-1:0] sh;
    logic [W-1:0] res;
    logic [3:0]   nflags;
    logic [W-1:0] mul_next;

    assign in_ready = reset_n & (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state == MUL);
    assign sh       = b[SW-1:0];
    assign mul_next = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath: result and next flags from sampled operands and current flags
    always_comb begin
        b_op   = b;
        cin    = 1'b0;
        res    = '0;
        nflags = flag_out;
        case (op)
            OP_SUB, OP_CMP: begin b_op = ~b; cin = 1'b1;        end
            OP_SBC:         begin b_op = ~b; cin = flag_out[1]; end
            OP_ADC:         begin            cin = flag_out[1]; end
            default:        ;
        endcase
        sum = {1'b0, a} + {1'b0, b_op} + {{W{1'b0}}, cin};
        // One guard bit on each side captures the last bit shifted out as C
        shl = {1'b0, a} << sh;
        shr = {a, 1'b0} >> sh;
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_ADC, OP_SBC: begin
                res    = sum[W-1:0];
                nflags = {(res == '0), res[W-1], sum[W],
                          a[W-1] ^ b_op[W-1] ^ sum[W-1] ^ sum[W]};
            end
            OP_AND: begin res = a & b; nflags[3:2] = {(res == '0), res[W-1]}; end
            OP_ORR: begin res = a | b; nflags[3:2] = {(res == '0), res[W-1]}; end
            OP_EOR: begin res = a ^ b; nflags[3:2] = {(res == '0), res[W-1]}; end
            OP_MOV: begin res = b;     nflags[3:2] = {(res == '0), res[W-1]}; end
            OP_LSL: begin
                res = shl[W-1:0];
                nflags[3:2] = {(res == '0), res[W-1]};
                if (sh != '0) nflags[1] = shl[W];
            end
            OP_LSR: begin
                res = shr[W:1];
                nflags[3:2] = {(res == '0), res[W-1]};
                if (sh != '0) nflags[1] = shr[0];
            end
            default: begin res = '0; nflags = flag_out; end
        endcase
    end

    // Handshake, FSM, result/flag registers and multiplier iteration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            data_out  <= '0;
            flag_out  <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            mul_sf    <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state  <= MUL;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            mul_sf <= set_flags;
                        end else begin
                            data_out  <= res;
                            out_valid <= 1'b1;
                            if (set_flags || op == OP_CMP) flag_out <= nflags;
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        data_out  <= mul_next;
                        out_valid <= 1'b1;
                        if (mul_sf) flag_out <= {(mul_next == '0), mul_next[W-1], flag_out[1:0]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the combinational datapath ALU. Accepts one operation per cycle over a valid/ready input port, returns a registered result over a valid/ready output port, and holds a persistent NZCV flag register. Adds carry-chained ADC/SBC, logical shifts and an iterative shift-add multiplier. Sits between the decode/operand-fetch stage and writeback of the datapath.

## Interface
- W, 32: datapath width; legal values 8..64.
- SW, $clog2(W): shift-amount width, derived, not overridden.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- op  in  4  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 ORR, 5 EOR, 6 MOV, 7 ADC, 8 SBC, 9 MUL, 10 LSL, 11 LSR; 12-15 reserved.
- set_flags  in  1  update flag register with this op's flags (CMP always updates).
- a  in  W  operand A.
- b  in  W  operand B; MOV source; shift amount in b[SW-1:0].
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer takes result.
- data_out  out  W  registered result.
- flag_out  out  4  registered flags: [3] Z, [2] N, [1] C, [0] V.
- busy  out  1  multiplier iterating.

## Operation
- Accept = in_valid & in_ready at a rising edge; a, b, op, set_flags sampled there.
- in_ready = (state == IDLE) & (~out_valid | out_ready).
- States: IDLE, MUL. IDLE->MUL on accepted MUL; MUL->IDLE after W iterations; other ops stay IDLE.
- Single-cycle ops: result and new flags computed from sampled operands and current flag_out, registered on the accept edge.
- ADD a+b; SUB/CMP a+~b+1; ADC a+b+C; SBC a+~b+C; all modulo 2^W.
- Arithmetic flags: Z = result==0; N = result[W-1]; C = carry out of bit W-1 (SUB/CMP/SBC: 1 means no borrow); V = carry into bit W-1 XOR carry out of bit W-1.
- AND/ORR/EOR/MOV: data_out = a&b, a|b, a^b, b; Z,N from result; C,V unchanged.
- LSL/LSR: shift a by s = b[SW-1:0], zero fill; C = last bit shifted out (a[W-s] for LSL, a[s-1] for LSR); s=0: C unchanged; V unchanged; Z,N from result.
- CMP: data_out = a-b; flags always updated regardless of set_flags.
- MUL: low W bits of a*b, unsigned radix-2 shift-add, one partial product per cycle over W cycles; Z,N from result; C,V unchanged.
- Reserved op: data_out = 0, flags unchanged, normal single-cycle handshake.
- Flags written only when the result is registered and set_flags=1 (or CMP); otherwise flag_out holds.
- Output held stable while out_valid & ~out_ready; out_valid drops on out_ready unless a new result is registered the same edge.
- in_valid while in_ready=0: ignored, no state change.

## Timing
- Reset (async assert, any state incl. mid-MUL): state IDLE, in_ready 0 while reset_n low then 1, out_valid 0, data_out 0, flag_out 0, busy 0, multiplier accumulator/counter cleared; in-flight MUL discarded.
- Single-cycle latency 1: accept at edge k, out_valid/data_out/flag_out valid after edge k.
- Throughput 1 op/cycle with out_ready held 1; back-to-back ADC sees C from the immediately preceding flag-setting op (no bubble).
- MUL: accept at edge k, busy=1 after k, in_ready=0 for W cycles, result and flags registered at edge k+W, busy=0 after k+W.
- Output stall: single-cycle op accepted same edge as out_ready consumes old result.
- Counter width SW+1; wraps only via state exit.

## Test plan
- W=32, ADD a=0x7FFFFFFF b=1 set_flags=1 -> data_out 0x80000000, flags N=1 Z=0 C=0 V=1, one cycle later.
- SUB a=5 b=5 set_flags=1, then ADC a=1 b=1 -> first 0 with Z=1 C=1; second 3 (C consumed), flags unchanged if set_flags=0.
- CMP a=3 b=7 set_flags=0 -> flags N=1 C=0 Z=0 V=0 updated; LSR a=0x3 b=1 set_flags=1 -> data_out 1, C=1.
- MUL a=0xFFFF b=0x10001 -> busy 32 cycles, in_ready low, data_out 0xFFFFFFFF N=1, C/V preserved.
- out_ready=0 for 5 cycles with continuous in_valid -> data_out stable, exactly one op accepted, no loss after release.
- reset_n pulsed low mid-MUL (cycle 10) -> all outputs 0 immediately, next op after release returns correct result.
